// File: rtl/jtag_ctrl_pkg.sv
// Shared types and constants for the JTAG scan controller.
package jtag_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_TAP_RESET = 2'b00,
    OP_IR_SCAN   = 2'b01,
    OP_DR_SCAN   = 2'b10,
    OP_RSVD      = 2'b11
  } op_t;

  typedef enum logic [3:0] {
    IDLE,
    RST_SEQ,
    SEL_DR,
    SEL_IR,
    CAPTURE,
    SHIFT,
    EXIT1,
    UPDATE,
    RTI,
    FINISH
  } ctrl_state_t;

  // TCKs in the TAP reset sequence (five TMS=1 then one TMS=0 into RTI)
  localparam int RST_SEQ_LEN = 6;
  // TCKs around the shift bits of a DR scan and an IR scan
  localparam int DR_OVERHEAD = 5;
  localparam int IR_OVERHEAD = 6;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: DIV clk cycles low, DIV clk cycles high, with single-cycle
// strobes that are high during the clk cycle ending in a TCK edge.
module jtag_tck_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(DIV - 1));
  assign rise = en & wrap & ~tck;
  assign fall = en & wrap & tck;

  // Half-period counter; parks with tck low whenever disabled
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_scan_ctrl.sv
// Host-side JTAG scan controller: runs a full IR/DR scan (or TAP reset) from
// one command, always starting and ending in Run-Test/Idle.
module jtag_scan_ctrl
  import jtag_ctrl_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int DIV     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [1:0]                   op,
  input  logic [$clog2(MAX_LEN+1)-1:0] len,
  input  logic [MAX_LEN-1:0]           tdi_data,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [MAX_LEN-1:0]           tdo_data,
  output logic                         tck,
  output logic                         tms,
  output logic                         tdi,
  input  logic                         tdo
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int CW = (LW > 3) ? LW : 3;
  localparam int IW = $clog2(MAX_LEN);

  ctrl_state_t        state;
  op_t                op_r;
  logic               tap_known;
  logic [CW-1:0]      bit_cnt;
  logic [CW-1:0]      len_r;
  logic [MAX_LEN-1:0] tdi_sr;
  logic               rise;
  logic               fall;
  logic               tck_en;
  logic               cmd_err;
  op_t                op_c;

  assign op_c    = op_t'(op);
  assign cmd_err = (op_c == OP_RSVD) ||
                   (op_c != OP_TAP_RESET && (len == '0 || int'(len) > MAX_LEN));
  // TCK runs only while a real scan is in flight, never for a rejected command
  assign tck_en  = busy && (state != FINISH);

  jtag_tck_gen #(.DIV(DIV)) u_tck_gen (
    .clk   (clk),
    .reset (reset),
    .en    (tck_en),
    .tck   (tck),
    .rise  (rise),
    .fall  (fall)
  );

  // Command FSM: accepts commands, steps TMS/TDI on each TCK fall, captures TDO on each rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the datapath registers are reset too, so an aborted scan leaves no stale capture or shift state behind.
      state     <= IDLE;
      op_r      <= OP_TAP_RESET;
      tap_known <= 1'b0;
      bit_cnt   <= '0;
      len_r     <= '0;
      tdi_sr    <= '0;
      tdo_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            tdo_data <= '0;
            op_r     <= op_c;
            len_r    <= CW'(len);
            tdi_sr   <= tdi_data;
            bit_cnt  <= '0;
            tms      <= 1'b1;
            tdi      <= 1'b0;
            if (cmd_err)
              state <= FINISH;
            else if (op_c == OP_TAP_RESET || !tap_known)
              state <= RST_SEQ;
            else
              state <= SEL_DR;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          err   <= 1'b1;
          state <= IDLE;
        end
        default: begin
          if (rise && (state == SHIFT || state == EXIT1))
            tdo_data[bit_cnt[IW-1:0]] <= tdo;
          if (fall) begin
            case (state)
              RST_SEQ: begin
                if (bit_cnt == CW'(RST_SEQ_LEN - 1)) begin
                  tap_known <= 1'b1;
                  bit_cnt   <= '0;
                  tms       <= 1'b1;
                  if (op_r == OP_TAP_RESET) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                  end else begin
                    state <= SEL_DR;
                  end
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  tms     <= (bit_cnt != CW'(RST_SEQ_LEN - 2));
                end
              end
              SEL_DR: begin
                bit_cnt <= '0;
                if (op_r == OP_IR_SCAN) begin
                  state <= SEL_IR;
                  tms   <= 1'b1;
                end else begin
                  state <= CAPTURE;
                  tms   <= 1'b0;
                end
              end
              SEL_IR: begin
                state <= CAPTURE;
                tms   <= 1'b0;
              end
              // Two TMS=0 TCKs: enter Capture, then enter Shift
              CAPTURE: begin
                if (bit_cnt == '0) begin
                  bit_cnt <= 1'b1;
                end else begin
                  bit_cnt <= '0;
                  tdi     <= tdi_sr[0];
                  if (len_r == CW'(1)) begin
                    state <= EXIT1;
                    tms   <= 1'b1;
                  end else begin
                    state <= SHIFT;
                  end
                end
              end
              // All shift bits but the last; the last one is the EXIT1 TCK
              SHIFT: begin
                tdi_sr  <= tdi_sr >> 1;
                tdi     <= tdi_sr[1];
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == len_r - CW'(2)) begin
                  state <= EXIT1;
                  tms   <= 1'b1;
                end
              end
              EXIT1: begin
                state <= UPDATE;
                tms   <= 1'b1;
                tdi   <= 1'b0;
              end
              UPDATE: begin
                state <= RTI;
                tms   <= 1'b0;
              end
              RTI: begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
                tms   <= 1'b1;
              end
              default: begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
